fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch initiator of the yarc core. Drives the single-port instruction memory read port (imem_read_o / imem_raddr_o / imem_rdata_i) and buffers the returned words in a small prefetch FIFO.
- Presents each instruction with its PC to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clk_i  in  1  core clock.
- rstn_i  in  1  reset; synchronous, active-low.
- imem_read_o  out  1  read request to instruction memory this cycle.
- imem_raddr_o  out  32  byte address of request; bits [1:0] always 0.
- imem_rdata_i  in  32  read data; valid the cycle after imem_read_o was high.
- redirect_i  in  1  pulse: discard all fetched state, restart at redirect_pc_i.
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (forced 0).
- instr_valid_o  out  1  instr_o/pc_o hold a valid instruction.
- instr_ready_i  in  1  decode accepts the head instruction this cycle.
- instr_o  out  32  instruction word.
- pc_o  out  32  byte address of instr_o.

Behaviour:
- Clock and reset: one clock domain. Reset is sampled only at posedge clk_i; no asynchronous reset paths.
- Reset state (rstn_i low):
  - fetch PC = RESET_PC; FIFO empty; in-flight flag cleared; discard flag cleared.
  - Outputs: instr_valid_o=0, imem_read_o=0, instr_o=0, pc_o=0.
- Memory protocol: synchronous read with fixed 1-cycle latency. Request in cycle N; imem_rdata_i is valid in cycle N+1. No backpressure from memory; at most 1 request in flight.
- Issue rule (combinational):
  - imem_read_o = rstn_i & ~redirect_i & (count + inflight - pop < DEPTH).
  - pop = instr_valid_o & instr_ready_i.
  - imem_raddr_o = fetch PC.
- Fetch PC:
  - Advances by 4 on each issued request; wraps 32'hFFFF_FFFC -> 32'h0000_0000.
  - Each request's PC travels with it into the FIFO.
- Response capture: in the cycle after an issue (inflight=1), {imem_rdata_i, PC} is written to the FIFO tail at the clock edge, unless the discard flag is set.
- FIFO:
  - Registered outputs; instr_valid_o = (count != 0).
  - Head visible the cycle after the write.
  - Simultaneous push and pop leave count unchanged.
  - Push never occurs when full; guaranteed by the issue rule. Assert this in simulation.
- Throughput: one instruction per cycle sustained with instr_ready_i held high, for any DEPTH >= 2.
- Latency:
  - First rstn_i-high cycle C: request to RESET_PC issued in C, data in C+1, instr_valid_o in C+2.
  - Redirect in cycle N: no request in N; request to target in N+1; instr_valid_o in N+3.
- Redirect (priority over all other events):
  - FIFO flushed at that edge; fetch PC = {redirect_pc_i[31:2],2'b00}.
  - If a response is due in N+1, the discard flag is set so that word is dropped.
  - A valid&ready handshake in the redirect cycle is void; decode must ignore it.
- Back-to-back redirects: each redirect overrides the previous one; only the last target is fetched.
- Stall: instr_ready_i low keeps instr_o/pc_o/instr_valid_o stable. Fetching stops once count+inflight = DEPTH.
- Reset mid-operation: all state returns to reset values at the next edge. An in-flight response arriving after reset is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Enabled:
  - Adds outputs perf_fetched_o [31:0] (instructions popped) and perf_stall_o [31:0] (cycles with instr_valid_o=0 outside reset).
  - Both reset to 0, wrap at 2^32, excluded from redirect flush.
- Disabled: ports and counters absent; no other behaviour changes.

Test Plan:
- Reset exit, memory word[i]=0x1000+i, ready=1 -> valid from cycle C+2. PCs 0x0,0x4,0x8,... with instr 0x1000,0x1001,... every cycle, no gaps.
- ready=0 for 10 cycles, DEPTH=4 -> imem_read_o drops after 4 outstanding+buffered. Head stays pc 0x0. On ready=1, PCs continue 0x0,0x4,... with no loss or duplication.
- Redirect to 0x0000_0103 while fetching PC 0x20 with a word in flight -> in-flight word dropped. Next request at 0x100; first valid pc_o=0x100 at N+3.
- Redirect in the same cycle as valid&ready -> that instruction is not counted. Next accepted pc_o equals the redirect target.
- RESET_PC=32'hFFFF_FFF8 -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rstn_i low for 1 cycle with FIFO full -> valid=0 next cycle. Fetch restarts at RESET_PC; FETCH_PERF_EN counters read 0.

Source files
------------

// File: rtl/fetch_unit.sv
// yarc instruction-fetch initiator: 1-cycle imem port, prefetch FIFO, redirect flush.
// Optional perf counters are enabled with FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_read_o,
  output logic [31:0] imem_raddr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic          inflight_q;
  logic          discard_q;
  logic [31:0]   pend_pc_q;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ipc_q [DEPTH];

  logic          pop;
  logic          pop_eff;
  logic          push;
  logic [CW:0]   occ;

  always_comb begin
    pop     = instr_valid_o & instr_ready_i;
    pop_eff = pop & ~redirect_i;
    push    = inflight_q & ~discard_q & ~redirect_i;
    occ     = {1'b0, count_q}
            + {{CW{1'b0}}, inflight_q}
            - {{CW{1'b0}}, pop};
    imem_read_o = rstn_i & ~redirect_i
                & (occ < (CW+1)'(DEPTH));
  end

  assign imem_raddr_o  = pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = ins_q[rd_q];
  assign pc_o          = ipc_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      pend_pc_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        ipc_q[i] <= '0;
      end
    end else begin
      inflight_q <= imem_read_o;
      // a response still due after a redirect must not reach the FIFO
      discard_q  <= redirect_i & imem_read_o;
      if (imem_read_o) begin
        pend_pc_q <= pc_q;
      end
      if (redirect_i) begin
        pc_q    <= {redirect_pc_i[31:2], 2'b00};
        count_q <= '0;
        rd_q    <= '0;
        wr_q    <= '0;
      end else begin
        if (imem_read_o) begin
          pc_q <= pc_q + 32'd4;
        end
        if (push) begin
          ins_q[wr_q] <= imem_rdata_i;
          ipc_q[wr_q] <= pend_pc_q;
          wr_q        <= wr_q + 1'b1;
        end
        if (pop_eff) begin
          rd_q <= rd_q + 1'b1;
        end
        if (push && !pop_eff) begin
          count_q <= count_q + 1'b1;
        end else if (!push && pop_eff) begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

  no_push_when_full: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    !(push && !pop_eff && (count_q == CW'(DEPTH)))
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop_eff) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (!instr_valid_o) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model plus directed latency checks.
// Random phase mixes stalls, redirects and resets.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        read, read2;
  logic [31:0] raddr, raddr2;
  logic [31:0] rdata = '0, rdata2 = '0;
  logic        redirect = 1'b0;
  logic [31:0] tgt = '0;
  logic        valid, valid2;
  logic        ready = 1'b1;
  logic [31:0] ins, ins2, pc, pc2;
  logic        zero = 1'b0;
  logic        one = 1'b1;
  logic [31:0] zero32 = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] pf_fetch, pf_stall, pf_fetch2, pf_stall2;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .imem_read_o(read), .imem_raddr_o(raddr), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(tgt),
    .instr_valid_o(valid), .instr_ready_i(ready),
    .instr_o(ins), .pc_o(pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched_o(pf_fetch), .perf_stall_o(pf_stall)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk_i(clk), .rstn_i(rstn),
    .imem_read_o(read2), .imem_raddr_o(raddr2), .imem_rdata_i(rdata2),
    .redirect_i(zero), .redirect_pc_i(zero32),
    .instr_valid_o(valid2), .instr_ready_i(one),
    .instr_o(ins2), .pc_o(pc2)
`ifdef FETCH_PERF_EN
    , .perf_fetched_o(pf_fetch2), .perf_stall_o(pf_stall2)
`endif
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  // idle cycles return junk so a mistimed capture shows up
  always @(posedge clk) begin
    rdata  <= read  ? memw(raddr)  : $urandom;
    rdata2 <= read2 ? memw(raddr2) : $urandom;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] fpc;
  logic [31:0] pend;
  bit          infl;
  bit          in_rst;
  bit          chk_en = 0;
  logic [31:0] m_fetch, m_stall;

  function automatic bit exp_read();
    int occ;
    occ = q.size() + int'(infl) - ((q.size() != 0 && ready) ? 1 : 0);
    return rstn && !redirect && (occ < DEPTH);
  endfunction

  always @(posedge clk) begin
    bit rd;
    if (!rstn) begin
      q.delete();
      fpc = 32'h0; infl = 0; in_rst = 1;
      m_fetch = 0; m_stall = 0;
    end else begin
      rd = exp_read();
      in_rst = 0;
      if (q.size() == 0) m_stall++;
      if (redirect) begin
        q.delete();
        fpc = {tgt[31:2], 2'b00};
        infl = 0;
      end else begin
        if (q.size() != 0 && ready) begin
          void'(q.pop_front());
          m_fetch++;
        end
        if (infl) q.push_back('{pc: pend, ins: memw(pend)});
        infl = rd;
        if (rd) begin
          pend = fpc;
          fpc += 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", {31'b0, valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("m_pc", pc, q[0].pc);
        chk("m_instr", ins, q[0].ins);
      end
      chk("m_read", {31'b0, read}, {31'b0, exp_read()});
      if (exp_read()) chk("m_raddr", raddr, fpc);
      if (in_rst) begin
        chk("rst_instr", ins, 32'h0);
        chk("rst_pc", pc, 32'h0);
      end
`ifdef FETCH_PERF_EN
      chk("m_perf_fetch", pf_fetch, m_fetch);
      chk("m_perf_stall", pf_stall, m_stall);
`endif
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nreads;
    // reset exit: valid at C+2, gapless stream
    rstn = 0; ready = 1; redirect = 0;
    next_cycle();
    chk_en = 1;
    next_cycle();
    next_cycle();
    rstn = 1;
    @(negedge clk);
    chk("c_read", {31'b0, read}, 32'h1);
    chk("c_raddr", raddr, 32'h0);
    chk("c_valid", {31'b0, valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("c1_valid", {31'b0, valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("c2_valid", {31'b0, valid}, 32'h1);
    chk("c2_pc", pc, 32'h0);
    chk("c2_instr", ins, 32'h1000);
    chk("d2_pc0", pc2, 32'hFFFF_FFF8);
    chk("d2_ins0", ins2, 32'h4000_0FFE);
    next_cycle();
    @(negedge clk);
    chk("c3_pc", pc, 32'h4);
    chk("c3_instr", ins, 32'h1001);
    chk("d2_pc1", pc2, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("c4_pc", pc, 32'h8);
    chk("d2_pc2", pc2, 32'h0);
    chk("d2_ins2", ins2, 32'h1000);

    // stall right after reset: exactly DEPTH requests go out
    rstn = 0; ready = 0;
    @(negedge clk);
    chk("r_read", {31'b0, read}, 32'h0);
    next_cycle();
    rstn = 1;
    nreads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read) nreads++;
      if (i < 9) next_cycle();
    end
    chk("stall_reads", nreads, DEPTH);
    chk("stall_head_pc", pc, 32'h0);
    chk("stall_valid", {31'b0, valid}, 32'h1);
    next_cycle();
    ready = 1;
    @(negedge clk);
    chk("resume_pc0", pc, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("resume_pc1", pc, 32'h4);
    next_cycle();
    @(negedge clk);
    chk("resume_pc2", pc, 32'h8);

    // reset with a full FIFO
    next_cycle();
    ready = 0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("full_valid", {31'b0, valid}, 32'h1);
    next_cycle();
    rstn = 0;
    next_cycle();
    rstn = 1;
    @(negedge clk);
    chk("rst2_valid", {31'b0, valid}, 32'h0);
    chk("rst2_raddr", raddr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst2_perf_f", pf_fetch, 32'h0);
    chk("rst2_perf_s", pf_stall, 32'h0);
`endif
    next_cycle();
    ready = 1;
    repeat (8) next_cycle();

    // redirect with a word in flight and a live handshake
    redirect = 1; tgt = 32'h0000_0103;
    @(negedge clk);
    chk("rd_hs_valid", {31'b0, valid}, 32'h1);
    chk("rd_read", {31'b0, read}, 32'h0);
    next_cycle();
    redirect = 0;
    @(negedge clk);
    chk("rd1_raddr", raddr, 32'h100);
    chk("rd1_valid", {31'b0, valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rd2_valid", {31'b0, valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rd3_pc", pc, 32'h100);
    chk("rd3_instr", ins, 32'h1040);

    // back-to-back redirects: only the last target is fetched
    next_cycle();
    redirect = 1; tgt = 32'h300;
    next_cycle();
    tgt = 32'h404;
    @(negedge clk);
    chk("bb_read", {31'b0, read}, 32'h0);
    next_cycle();
    redirect = 0;
    @(negedge clk);
    chk("bb_raddr", raddr, 32'h404);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("bb_pc", pc, 32'h404);
    chk("bb_instr", ins, 32'h1101);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rstn     = ($urandom_range(0, 199) != 0);
      redirect = rstn && ($urandom_range(0, 15) == 0);
      tgt      = $urandom;
      ready    = ($urandom_range(0, 3) != 0);
    end
    next_cycle();
    rstn = 1; redirect = 0; ready = 1;
    repeat (10) next_cycle();
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
